execute_stage: RTL and testbench

// - Y86-64 pipeline E stage: holds the D->E register, drives alu_64, owns the condition codes (CC), evaluates Cnd.
// - Holds the E->M register that feeds the memory stage; exports forwarding taps e_valE/e_dstE to decode.
// - Sits between the decode stage (upstream) and the memory stage (downstream); pipeline control drives the bubbles.

---
 rtl/y86_pkg.sv | 38 +++
 rtl/alu_64.sv | 30 +++
 rtl/cond_eval.sv | 26 ++
 rtl/execute_stage.sv | 136 +++++++++++++
 tb/tb_execute_stage.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, ALU ops and
// condition function codes used across the pipeline stages.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] STAT_HLT = 4'h2;
  localparam logic [3:0] STAT_ADR = 4'h3;
  localparam logic [3:0] STAT_INS = 4'h4;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

endpackage

// File: rtl/alu_64.sv
// W-bit ALU: add, sub (a-b), and, xor, with signed overflow for add/sub.
module alu_64 #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   Control,
  output logic [W-1:0] Out,
  output logic         Overflow
);
  import y86_pkg::*;

  always_comb begin
    Out      = '0;
    Overflow = 1'b0;
    case (Control)
      ALU_ADD: begin
        Out      = a + b;
        Overflow = (a[W-1] == b[W-1]) && (Out[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        Out      = a - b;
        Overflow = (a[W-1] != b[W-1]) && (Out[W-1] != a[W-1]);
      end
      ALU_AND: Out = a & b;
      default: Out = a ^ b;
    endcase
  end

endmodule

// File: rtl/cond_eval.sv
// Condition evaluation from the {ZF,SF,OF} flags and a jXX/cmovXX function code.
module cond_eval (
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd
);
  import y86_pkg::*;

  logic zf, sf, of;
  assign {zf, sf, of} = cc;

  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = (sf ^ of) | zf;
      C_L:     cnd = sf ^ of;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~(sf ^ of);
      C_G:     cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: D->E register, ALU operand muxing, condition codes,
// Cnd evaluation and the E->M register feeding the memory stage.
module execute_stage #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   d_stat,
  input  logic [3:0]   d_icode,
  input  logic [3:0]   d_ifun,
  input  logic [W-1:0] d_valC,
  input  logic [W-1:0] d_valA,
  input  logic [W-1:0] d_valB,
  input  logic [3:0]   d_dstE,
  input  logic [3:0]   d_dstM,
  input  logic         E_bubble,
  input  logic         M_bubble,
  input  logic         m_exc,
  input  logic         W_exc,
  output logic [W-1:0] e_valE,
  output logic [3:0]   e_dstE,
  output logic         e_Cnd,
  output logic [3:0]   M_stat,
  output logic [3:0]   M_icode,
  output logic         M_Cnd,
  output logic [W-1:0] M_valE,
  output logic [W-1:0] M_valA,
  output logic [3:0]   M_dstE,
  output logic [3:0]   M_dstM,
  output logic [2:0]   cc_out
);
  import y86_pkg::*;

  typedef struct packed {
    logic [3:0]   stat;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] valC;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic [3:0]   dstE;
    logic [3:0]   dstM;
  } e_reg_t;

  localparam e_reg_t E_NOP = '{stat: STAT_AOK, icode: ICODE_NOP, ifun: 4'h0,
                               valC: '0, valA: '0, valB: '0,
                               dstE: RNONE, dstM: RNONE};

  e_reg_t       e_r;
  logic [2:0]   cc;
  logic [W-1:0] alu_a, alu_b, alu_out;
  logic [1:0]   alu_fun;
  logic         alu_of, set_cc, new_of;

  // D->E register; a bubble overrides whatever decode presents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        e_r <= E_NOP;
    else if (E_bubble) e_r <= E_NOP;
    else               e_r <= '{stat: d_stat, icode: d_icode, ifun: d_ifun,
                                valC: d_valC, valA: d_valA, valB: d_valB,
                                dstE: d_dstE, dstM: d_dstM};
  end

  always_comb begin
    alu_a = '0;
    case (e_r.icode)
      ICODE_RRMOVQ, ICODE_OPQ:                     alu_a = e_r.valA;
      ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ:    alu_a = e_r.valC;
      ICODE_CALL, ICODE_PUSHQ:                     alu_a = {W{1'b0}} - W'(8);
      ICODE_RET, ICODE_POPQ:                       alu_a = W'(8);
      default:                                     alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (e_r.icode)
      ICODE_RMMOVQ, ICODE_MRMOVQ, ICODE_OPQ, ICODE_CALL,
      ICODE_PUSHQ, ICODE_RET, ICODE_POPQ:          alu_b = e_r.valB;
      default:                                     alu_b = '0;
    endcase
  end

  assign alu_fun = (e_r.icode == ICODE_OPQ) ? e_r.ifun[1:0] : ALU_ADD;

  // operands are swapped so that subq computes valB - valA
  alu_64 #(.W(W)) u_alu (
    .a        (alu_b),
    .b        (alu_a),
    .Control  (alu_fun),
    .Out      (alu_out),
    .Overflow (alu_of)
  );

  assign e_valE = alu_out;

  // exceptions further down the pipe freeze CC so state stays precise
  assign set_cc = (e_r.icode == ICODE_OPQ) & ~m_exc & ~W_exc;
  assign new_of = (e_r.ifun == 4'h0 || e_r.ifun == 4'h1) ? alu_of : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cc <= 3'b100;
    else if (set_cc) cc <= {(alu_out == '0), alu_out[W-1], new_of};
  end

  assign cc_out = cc;

  cond_eval u_cond (
    .cc   (cc),
    .ifun (e_r.ifun),
    .cnd  (e_Cnd)
  );

  assign e_dstE = (e_r.icode == ICODE_RRMOVQ && !e_Cnd) ? RNONE : e_r.dstE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || M_bubble) begin
      M_stat  <= STAT_AOK;
      M_icode <= ICODE_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= '0;
      M_valA  <= '0;
      M_dstE  <= RNONE;
      M_dstM  <= RNONE;
    end else begin
      M_stat  <= e_r.stat;
      M_icode <= e_r.icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= e_valE;
      M_valA  <= e_r.valA;
      M_dstE  <= e_dstE;
      M_dstM  <= e_r.dstM;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: hand-computed ALU, CC, Cnd and bubble cases.
module tb_execute_stage;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  d_stat, d_icode, d_ifun, d_dstE, d_dstM;
  logic [63:0] d_valC, d_valA, d_valB;
  logic        E_bubble, M_bubble, m_exc, W_exc;
  logic [63:0] e_valE, M_valE, M_valA;
  logic [3:0]  e_dstE, M_stat, M_icode, M_dstE, M_dstM;
  logic        e_Cnd, M_Cnd;
  logic [2:0]  cc_out;

  int nchk = 0;
  int npass = 0;

  always #5 clk = ~clk;

  execute_stage #(.W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
    .d_dstE(d_dstE), .d_dstM(d_dstM),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .m_exc(m_exc), .W_exc(W_exc),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .cc_out(cc_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic ld(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] c,
                    input logic [63:0] a, input logic [63:0] b, input logic [3:0] de);
    d_stat = STAT_AOK; d_icode = ic; d_ifun = fn;
    d_valC = c; d_valA = a; d_valB = b; d_dstE = de; d_dstM = RNONE;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; E_bubble = 0; M_bubble = 0; m_exc = 0; W_exc = 0;
    ld(ICODE_NOP, 0, 0, 0, 0, RNONE);
    repeat (2) step();
    chk("rst_M_icode", 64'(M_icode), 64'h1);
    chk("rst_M_stat",  64'(M_stat),  64'h1);
    chk("rst_M_dstE",  64'(M_dstE),  64'hF);
    chk("rst_cc",      64'(cc_out),  64'h4);
    rst_n = 1'b1;

    // subq 5 from 3, then cmovl
    ld(ICODE_OPQ, 4'h1, 0, 64'd5, 64'd3, 4'h2);
    step();
    chk("subq_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("subq_cc_pre", 64'(cc_out), 64'h4);
    ld(ICODE_RRMOVQ, C_L, 0, 64'd77, 0, 4'h3);
    step();
    chk("subq_cc", 64'(cc_out), 64'h2);
    chk("subq_M_valE", M_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("subq_M_icode", 64'(M_icode), 64'h6);
    chk("cmovl_cnd", 64'(e_Cnd), 64'h1);
    chk("cmovl_dstE", 64'(e_dstE), 64'h3);
    chk("cmovl_valE", e_valE, 64'd77);

    // signed overflow on addq; then cmovl not taken, cmovge taken
    ld(ICODE_OPQ, 4'h0, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h4);
    step();
    chk("addq_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("cmovl_M_Cnd", 64'(M_Cnd), 64'h1);
    chk("cmovl_M_dstE", 64'(M_dstE), 64'h3);
    ld(ICODE_RRMOVQ, C_L, 0, 64'd9, 0, 4'h5);
    step();
    chk("addq_cc", 64'(cc_out), 64'h3);
    chk("cmovl2_cnd", 64'(e_Cnd), 64'h0);
    chk("cmovl2_dstE", 64'(e_dstE), 64'hF);
    ld(ICODE_RRMOVQ, C_GE, 0, 64'd9, 0, 4'h6);
    step();
    chk("cmovge_cnd", 64'(e_Cnd), 64'h1);
    chk("cmovge_dstE", 64'(e_dstE), 64'h6);
    chk("cmovl2_M_dstE", 64'(M_dstE), 64'hF);
    chk("cmovl2_M_Cnd", 64'(M_Cnd), 64'h0);

    // stack pointer arithmetic and immediate moves leave CC alone
    ld(ICODE_PUSHQ, 0, 0, 0, 64'h100, 4'h4);
    step();
    chk("pushq_valE", e_valE, 64'hF8);
    ld(ICODE_POPQ, 0, 0, 0, 64'h100, 4'h4);
    step();
    chk("popq_valE", e_valE, 64'h108);
    ld(ICODE_IRMOVQ, 0, 64'd42, 0, 0, 4'h1);
    step();
    chk("irmovq_valE", e_valE, 64'd42);
    chk("stack_cc", 64'(cc_out), 64'h3);

    // xorq with memory-stage exception: no CC update
    ld(ICODE_OPQ, 4'h3, 0, 64'hA5, 64'hA5, 4'h1);
    m_exc = 1'b1;
    step();
    chk("xorq_valE", e_valE, 64'h0);
    ld(ICODE_NOP, 0, 0, 0, 0, RNONE);
    step();
    chk("xorq_exc_cc", 64'(cc_out), 64'h3);
    m_exc = 1'b0;
    ld(ICODE_OPQ, 4'h3, 0, 64'hA5, 64'hA5, 4'h1);
    step();
    ld(ICODE_NOP, 0, 0, 0, 0, RNONE);
    step();
    chk("xorq_cc", 64'(cc_out), 64'h4);

    // E bubble squashes the decode op
    ld(ICODE_OPQ, 4'h0, 0, 64'd1, 64'd1, 4'h7);
    E_bubble = 1'b1;
    step();
    E_bubble = 1'b0;
    ld(ICODE_NOP, 0, 0, 0, 0, RNONE);
    step();
    chk("ebub_M_icode", 64'(M_icode), 64'h1);
    chk("ebub_M_dstE", 64'(M_dstE), 64'hF);
    chk("ebub_M_valE", M_valE, 64'h0);
    chk("ebub_cc", 64'(cc_out), 64'h4);

    // both bubbles at once
    ld(ICODE_IRMOVQ, 0, 64'd5, 0, 0, 4'h3);
    step();
    ld(ICODE_OPQ, 4'h1, 0, 64'd1, 64'd0, 4'h2);
    E_bubble = 1'b1; M_bubble = 1'b1;
    step();
    chk("bb_M_icode", 64'(M_icode), 64'h1);
    chk("bb_M_dstE", 64'(M_dstE), 64'hF);
    chk("bb_M_valE", M_valE, 64'h0);
    E_bubble = 1'b0; M_bubble = 1'b0;
    ld(ICODE_NOP, 0, 0, 0, 0, RNONE);
    step();
    chk("bb_M_icode2", 64'(M_icode), 64'h1);
    chk("bb_cc", 64'(cc_out), 64'h4);

    // asynchronous reset mid-cycle
    ld(ICODE_OPQ, 4'h0, 0, 64'd1, 64'd0, 4'h2);
    step();
    ld(ICODE_NOP, 0, 0, 0, 0, RNONE);
    step();
    chk("pre_rst_M_icode", 64'(M_icode), 64'h6);
    chk("pre_rst_cc", 64'(cc_out), 64'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_M_icode", 64'(M_icode), 64'h1);
    chk("arst_M_dstE", 64'(M_dstE), 64'hF);
    chk("arst_cc", 64'(cc_out), 64'h4);
    chk("arst_e_dstE", 64'(e_dstE), 64'hF);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
